gencon: RTL and testbench
=========================

GENCON -- requirements
Module: gencon

Interface
REQ-001 One clock; reset is synchronous and active-low; ports are named clk and nRST.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 nRST  input  1  synchronous active-low reset.
REQ-004 keypad_input  input  4  digit value, 0-9; values 10-15 are ignored.
REQ-005 read_input  input  1  digit strobe; one digit is accepted per rising edge (0->1) of this signal.
REQ-006 operator_input  input  3  one-hot operator: 001 add, 010 subtract, 100 multiply, 000 none; any other code is ignored.
REQ-007 equal_input  input  1  request to compute the result.
REQ-008 complete  output  1  high while a valid result is displayed.
REQ-009 display_output  output  16  operand currently being entered, or the result once computed.
REQ-010 Internal nets SHALL carry exactly these names so a bench can override them hierarchically: ALU_in1, ALU_in2 (16), addOrSub (1=subtract), start_ALU, ALU_finish, ALU_out (16), mult_in1, mult_in2 (16), start_mult, mult_finish, mult_out (16).

Function
REQ-011 States: OP1, OP2, CALC_ADD, CALC_MULT, DONE.
REQ-012 Digit entry, on a read_input rising edge with a digit of 0-9: operand <= operand*10 + digit, truncated modulo 2^16.
REQ-013 read_input SHALL be edge-detected with a registered previous value; a strobe held high enters exactly one digit.
REQ-014 OP1: digits build operand1.
REQ-015 OP1: a valid operator latches the operator, clears operand2 to 0, and moves to OP2.
REQ-016 OP1: equal_input is ignored.
REQ-017 OP2: digits build operand2; operator_input is ignored.
REQ-018 OP2: equal_input moves to CALC_ADD (add or subtract) or CALC_MULT (multiply).
REQ-019 A valid operator and a digit edge in the same cycle: the operator wins and the digit is dropped.
REQ-020 CALC_ADD: start_ALU pulses high for exactly one cycle, with ALU_in1=operand1, ALU_in2=operand2, and addOrSub set from the operator.
REQ-021 CALC_ADD: the controller holds until ALU_finish=1, then registers ALU_out as the result and enters DONE.
REQ-022 CALC_MULT: same handshake as CALC_ADD, using start_mult, mult_in1, mult_in2, mult_finish and mult_out.
REQ-023 The finish signal may rise in the same cycle as the start pulse; the minimum latency from the equal_input edge to complete=1 is 2 cycles.
REQ-024 Default internal engines: a combinational adder/subtractor and an iterative shift-add multiplier (16 cycles).
REQ-025 Both engines assert their finish signal for one cycle and produce the low 16 bits of the two's-complement result (wraps on overflow).
REQ-026 DONE: complete=1 and display_output=result.
REQ-027 DONE: a digit edge clears operand1 to the digit value, clears complete, and returns to OP1; other inputs are ignored.
REQ-028 display_output SHALL be operand1 in OP1, operand2 in OP2, the held operand2 in CALC_*, and the result in DONE.
REQ-029 complete SHALL be registered and high only in DONE.

Reset
REQ-030 While nRST=0 at a clock edge: state=OP1, operands, operator, result and edge register cleared to 0.
REQ-031 While nRST=0: complete=0, display_output=0, start_ALU=start_mult=0.
REQ-032 Reset mid-calculation SHALL abort the calculation; any later finish is ignored until the next calculation starts.

Structure
REQ-033 Shared package gencon_pkg SHALL hold the operator encodings (OP_ADD=3'b001, OP_SUB=3'b010, OP_MUL=3'b100) and the state enum.
REQ-034 Sub-module gencon_mult SHALL be the iterative multiplier (start/finish handshake); the adder SHALL be inline in gencon.

Verification
REQ-035 Reset; digits 1,1; operator 100; digits 1,0; equal -> complete=1, display_output=110.
REQ-036 Reset; digits 1,1; operator 001; digits 1,0; equal -> display_output=21.
REQ-037 Digits 5; operator 010; digits 1,2; equal -> display_output=16'hFFF9 (-7).
REQ-038 read_input held high 5 cycles with digit 7 -> operand=7; keypad_input=12 strobed -> operand unchanged.
REQ-039 nRST asserted while in CALC_MULT -> complete=0, display_output=0, state OP1; the next entry 2+3= -> 5.
REQ-040 Digits 9,9,9,9,9 -> display_output=99999 mod 65536=34463.

Source files
------------

// File: rtl/gencon_pkg.sv
// Shared definitions for the gencon keypad calculator: operator codes,
// controller states and the decimal digit-append helper.
package gencon_pkg;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b100;

  typedef enum logic [2:0] {
    OP1       = 3'd0,
    OP2       = 3'd1,
    CALC_ADD  = 3'd2,
    CALC_MULT = 3'd3,
    DONE      = 3'd4
  } state_t;

  // Shift one decimal digit into an operand; the product wraps at 16 bits.
  function automatic logic [15:0] append_digit(input logic [15:0] value,
                                               input logic [3:0]  digit);
    return value * 16'd10 + {12'd0, digit};
  endfunction

endpackage

// File: rtl/gencon_mult.sv
// Iterative shift-add multiplier. A start pulse loads the operands; sixteen
// cycles later finish pulses for one cycle with the low 16 product bits held.
module gencon_mult (
  input  logic        clk,
  input  logic        nRST,
  input  logic        start,
  input  logic [15:0] mult_a,
  input  logic [15:0] mult_b,
  output logic        finish,
  output logic [15:0] product
);

  logic [15:0] mcand;
  logic [15:0] mplier;
  logic [15:0] acc;
  logic [15:0] acc_next;
  logic [3:0]  count;
  logic        busy;

  assign acc_next = acc + (mplier[0] ? mcand : 16'd0);
  assign product  = acc;

  // Load on start, then add the shifted multiplicand for each set multiplier bit.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      busy   <= 1'b0;
      finish <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else begin
      finish <= 1'b0;
      if (start) begin
        acc    <= '0;
        mcand  <= mult_a;
        mplier <= mult_b;
        count  <= '0;
        busy   <= 1'b1;
      end else if (busy) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + 4'd1;
        if (count == 4'd15) begin
          busy   <= 1'b0;
          finish <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gencon.sv
// Keypad calculator controller: builds two decimal operands from digit
// strobes, runs add/subtract inline or multiply on gencon_mult, shows result.
// Engine handshake: start_* is a one-cycle request with inputs stable while
// the controller waits in CALC_*; *_finish is a one-cycle done pulse that may
// coincide with the start pulse, and *_out is captured in that cycle.
module gencon (
  input  logic        clk,
  input  logic        nRST,
  input  logic [3:0]  keypad_input,
  input  logic        read_input,
  input  logic [2:0]  operator_input,
  input  logic        equal_input,
  output logic        complete,
  output logic [15:0] display_output,
  output logic [2:0]  dbg_state
);
  import gencon_pkg::*;

  state_t      state, state_next;
  logic [15:0] operand1, operand1_next;
  logic [15:0] operand2, operand2_next;
  logic [15:0] result, result_next;
  logic [2:0]  op_reg, op_next;
  logic        read_prev;
  logic        calc_started;
  logic        digit_edge;
  logic        op_valid;

  logic [15:0] ALU_in1, ALU_in2, ALU_out;
  logic        addOrSub, start_ALU, ALU_finish;
  logic [15:0] mult_in1, mult_in2, mult_out;
  logic        start_mult, mult_finish;

  assign digit_edge = read_input && !read_prev && (keypad_input <= 4'd9);
  assign op_valid   = (operator_input == OP_ADD) || (operator_input == OP_SUB) ||
                      (operator_input == OP_MUL);
  assign dbg_state  = state;

  // Start pulses only on the first cycle spent in a calculation state.
  assign start_ALU  = (state == CALC_ADD)  && !calc_started;
  assign start_mult = (state == CALC_MULT) && !calc_started;

  // Inline adder/subtractor: combinational, so it finishes with its start.
  assign ALU_in1    = operand1;
  assign ALU_in2    = operand2;
  assign addOrSub   = (op_reg == OP_SUB);
  assign ALU_out    = addOrSub ? (ALU_in1 - ALU_in2) : (ALU_in1 + ALU_in2);
  assign ALU_finish = start_ALU;

  assign mult_in1 = operand1;
  assign mult_in2 = operand2;

  gencon_mult u_mult (
    .clk     (clk),
    .nRST    (nRST),
    .start   (start_mult),
    .mult_a  (mult_in1),
    .mult_b  (mult_in2),
    .finish  (mult_finish),
    .product (mult_out)
  );

  // Next-state and next-datapath decode; an operator beats a same-cycle digit.
  always_comb begin
    state_next    = state;
    operand1_next = operand1;
    operand2_next = operand2;
    op_next       = op_reg;
    result_next   = result;
    case (state)
      OP1: begin
        if (op_valid) begin
          op_next       = operator_input;
          operand2_next = '0;
          state_next    = OP2;
        end else if (digit_edge) begin
          operand1_next = append_digit(operand1, keypad_input);
        end
      end
      OP2: begin
        if (equal_input) begin
          state_next = (op_reg == OP_MUL) ? CALC_MULT : CALC_ADD;
        end else if (digit_edge) begin
          operand2_next = append_digit(operand2, keypad_input);
        end
      end
      CALC_ADD: begin
        if (ALU_finish) begin
          result_next = ALU_out;
          state_next  = DONE;
        end
      end
      CALC_MULT: begin
        if (mult_finish) begin
          result_next = mult_out;
          state_next  = DONE;
        end
      end
      DONE: begin
        if (digit_edge) begin
          operand1_next = {12'd0, keypad_input};
          state_next    = OP1;
        end
      end
      default: state_next = OP1;
    endcase
  end

  // Display mux: the operand being edited, the held operand2, or the result.
  always_comb begin
    display_output = operand1;
    case (state)
      OP2, CALC_ADD, CALC_MULT: display_output = operand2;
      DONE:                     display_output = result;
      default:                  display_output = operand1;
    endcase
  end

  // State and datapath registers; complete is registered from the next state.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state        <= OP1;
      operand1     <= '0;
      operand2     <= '0;
      op_reg       <= OP_NONE;
      result       <= '0;
      read_prev    <= 1'b0;
      complete     <= 1'b0;
      calc_started <= 1'b0;
    end else begin
      state        <= state_next;
      operand1     <= operand1_next;
      operand2     <= operand2_next;
      op_reg       <= op_next;
      result       <= result_next;
      read_prev    <= read_input;
      complete     <= (state_next == DONE);
      calc_started <= (state == CALC_ADD) || (state == CALC_MULT);
    end
  end

endmodule

// File: tb/tb_gencon.sv
// Bench for gencon: table of calculations, hand sequences for strobe/reset
// corner cases, and random calculations against an arithmetic model.
module tb_gencon;
  import gencon_pkg::*;

  logic        clk;
  logic        nRST;
  logic [3:0]  keypad_input;
  logic        read_input;
  logic [2:0]  operator_input;
  logic        equal_input;
  logic        complete;
  logic [15:0] display_output;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fails  = 0;

  gencon dut (
    .clk            (clk),
    .nRST           (nRST),
    .keypad_input   (keypad_input),
    .read_input     (read_input),
    .operator_input (operator_input),
    .equal_input    (equal_input),
    .complete       (complete),
    .display_output (display_output),
    .dbg_state      (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[8];

  // Scoreboard helpers
  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, got, got, exp, exp);
    end
  endtask

  task automatic check_state(input string name, input state_t exp);
    n_checks++;
    if (dbg_state !== exp) begin
      n_fails++;
      $display("FAIL %s: state got %0d expected %0d", name, dbg_state, exp);
    end
  endtask

  // Reference model: plain integer arithmetic reduced modulo 2^16.
  function automatic logic [15:0] ref_calc(input logic [15:0] a, input logic [15:0] b,
                                           input logic [2:0] op);
    longint r;
    case (op)
      OP_ADD:  r = longint'(a) + longint'(b);
      OP_SUB:  r = longint'(a) - longint'(b);
      default: r = longint'(a) * longint'(b);
    endcase
    r = ((r % 65536) + 65536) % 65536;
    return r[15:0];
  endfunction

  // Driver tasks: all inputs change on the falling edge.
  task automatic do_reset();
    @(negedge clk);
    nRST = 1'b0; keypad_input = '0; read_input = 1'b0;
    operator_input = OP_NONE; equal_input = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nRST = 1'b1;
  endtask

  task automatic press_digit(input logic [3:0] d, input int hold);
    keypad_input = d;
    read_input   = 1'b1;
    repeat (hold) @(negedge clk);
    read_input   = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_op(input logic [2:0] op);
    operator_input = op;
    @(negedge clk);
    operator_input = OP_NONE;
    @(negedge clk);
  endtask

  task automatic press_equal();
    equal_input = 1'b1;
    @(negedge clk);
    equal_input = 1'b0;
  endtask

  task automatic type_number(input logic [15:0] v, input bit noisy);
    int q[$];
    int x;
    x = v;
    if (x == 0) q.push_back(0);
    while (x > 0) begin
      q.push_front(x % 10);
      x = x / 10;
    end
    foreach (q[i]) begin
      if (noisy && ($urandom_range(0, 3) == 0))
        press_digit(4'($urandom_range(10, 15)), 1);
      press_digit(4'(q[i]), noisy ? $urandom_range(1, 3) : 1);
    end
  endtask

  task automatic wait_complete(input string name, input int budget, output int cycles);
    cycles = 0;
    while (!complete && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    if (!complete) begin
      n_checks++;
      n_fails++;
      $display("FAIL %s: complete not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic run_calc(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] op, input logic [15:0] exp, input bit noisy);
    int cyc;
    type_number(a, noisy);
    check({name, " op1"}, display_output, a);
    press_op(op);
    check({name, " op2 cleared"}, display_output, 16'd0);
    type_number(b, noisy);
    check({name, " op2"}, display_output, b);
    press_equal();
    wait_complete(name, 40, cyc);
    check({name, " result"}, display_output, exp);
    check({name, " complete"}, {15'd0, complete}, 16'd1);
  endtask

  // Test sequence
  initial begin
    int cyc;
    logic [2:0]  ops[3];
    logic [15:0] a, b, m;
    logic [2:0]  op;

    ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_MUL;

    vecs[0] = '{16'd11,    16'd10,  OP_MUL, 16'd110};
    vecs[1] = '{16'd11,    16'd10,  OP_ADD, 16'd21};
    vecs[2] = '{16'd5,     16'd12,  OP_SUB, 16'hFFF9};
    vecs[3] = '{16'd65535, 16'd1,   OP_ADD, 16'd0};
    vecs[4] = '{16'd0,     16'd1,   OP_SUB, 16'hFFFF};
    vecs[5] = '{16'd300,   16'd300, OP_MUL, 16'd24464};
    vecs[6] = '{16'd255,   16'd257, OP_MUL, 16'd65535};
    vecs[7] = '{16'd1000,  16'd999, OP_SUB, 16'd1};

    nRST = 1'b0; keypad_input = '0; read_input = 1'b0;
    operator_input = OP_NONE; equal_input = 1'b0;
    do_reset();
    check("reset complete", {15'd0, complete}, 16'd0);
    check("reset display", display_output, 16'd0);
    check_state("reset state", OP1);

    // Table of calculations, each starting from reset
    for (int i = 0; i < 8; i++) begin
      do_reset();
      run_calc($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, 1'b0);
    end

    // Add latency: equal raised, complete two cycles later
    do_reset();
    type_number(16'd3, 1'b0);
    press_op(OP_ADD);
    type_number(16'd4, 1'b0);
    press_equal();
    check("add latency first cycle", {15'd0, complete}, 16'd0);
    @(negedge clk);
    check("add latency second cycle", {15'd0, complete}, 16'd1);
    check("add latency value", display_output, 16'd7);

    // From DONE, a digit restarts operand1 and clears complete
    press_digit(4'd4, 1);
    check("done digit display", display_output, 16'd4);
    check("done digit complete", {15'd0, complete}, 16'd0);
    check_state("done digit state", OP1);

    // Held strobe enters one digit; out-of-range digit ignored
    do_reset();
    press_digit(4'd7, 5);
    check("held strobe", display_output, 16'd7);
    press_digit(4'd12, 1);
    check("digit 12 ignored", display_output, 16'd7);

    // Equal ignored while entering operand1
    press_equal();
    repeat (3) @(negedge clk);
    check("equal in op1 complete", {15'd0, complete}, 16'd0);
    check_state("equal in op1 state", OP1);

    // Five nines wrap modulo 2^16
    do_reset();
    m = 16'd0;
    for (int i = 0; i < 5; i++) begin
      press_digit(4'd9, 1);
      m = 16'((32'(m) * 10 + 9) % 65536);
    end
    check("99999 wrap model", display_output, m);
    check("99999 wrap", display_output, 16'd34463);

    // Operator and digit edge together: operator wins; OP2 ignores operators
    do_reset();
    press_digit(4'd5, 1);
    operator_input = OP_ADD; keypad_input = 4'd3; read_input = 1'b1;
    @(negedge clk);
    operator_input = OP_NONE; read_input = 1'b0;
    @(negedge clk);
    check("op beats digit display", display_output, 16'd0);
    check_state("op beats digit state", OP2);
    press_op(OP_MUL);
    press_digit(4'd4, 1);
    press_equal();
    wait_complete("op ignored in op2", 40, cyc);
    check("op ignored in op2 result", display_output, 16'd9);

    // Reset during multiply aborts it
    do_reset();
    type_number(16'd11, 1'b0);
    press_op(OP_MUL);
    type_number(16'd10, 1'b0);
    press_equal();
    repeat (3) @(negedge clk);
    check_state("in calc_mult", CALC_MULT);
    nRST = 1'b0;
    @(negedge clk);
    nRST = 1'b1;
    check("abort complete", {15'd0, complete}, 16'd0);
    check("abort display", display_output, 16'd0);
    check_state("abort state", OP1);
    repeat (20) @(negedge clk);
    check("abort stays idle", {15'd0, complete}, 16'd0);
    run_calc("after abort", 16'd2, 16'd3, OP_ADD, 16'd5, 1'b0);

    // Random calculations chained from DONE, with noisy strobes
    for (int i = 0; i < 25; i++) begin
      a  = 16'($urandom_range(0, 65535));
      b  = 16'($urandom_range(0, 65535));
      op = ops[$urandom_range(0, 2)];
      run_calc($sformatf("rand%0d", i), a, b, op, ref_calc(a, b, op), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
